mem_port_arbiter: RTL

- Sequences the single-ported unified instruction/data byte memory of the RISC-V pipeline.
- Shares the memory between two requesters: the IF-stage fetch port and the MEM-stage load/store port.
- Grants one access per cycle, registers the returned read data, and produces stall signals for the pipeline hazard unit.
- Has a bounded-starvation guarantee so fetch always makes progress.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arb_starve_ctr.sv | 29 ++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

    // Which requester owns the memory port this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } gnt_e;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // addi x0, x0, 0 -- returned for fetches outside the memory
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Access size in bytes from funct3[1:0]; 2'b11 is reported as 4 (rejected elsewhere)
    function automatic logic [2:0] f3_size(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating counter of consecutive cycles a pending fetch was denied.
module mem_arb_starve_ctr #(
    parameter int unsigned MAX = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam int unsigned CntW = (MAX < 2) ? 1 : $clog2(MAX + 1);

    logic [CntW-1:0] r_cnt;

    // Count denied cycles, stop at MAX, clear whenever fetch is served or idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CntW'(MAX))) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign o_at_max = (r_cnt == CntW'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one byte-addressed memory between IF fetch and MEM load/store.
// Optional perf counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 512,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic [31:0]       o_if_rdata,
    output logic              o_if_valid,
    input  logic              i_dm_read,
    input  logic              i_dm_write,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [31:0]       i_dm_wdata,
    input  logic [2:0]        i_dm_funct3,
    output logic              o_dm_gnt,
    output logic [31:0]       o_dm_rdata,
    output logic              o_dm_valid,
    output logic              o_dm_err,
    output logic              o_stall_if,
    output logic              o_stall_dm,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [2:0]        o_mem_funct3,
    input  logic [31:0]       i_mem_rdata,
    output logic [31:0]       o_perf_if_stall,
    output logic [31:0]       o_perf_dm_gnt
);

    gnt_e              w_gnt;
    logic              w_dm_req;
    logic              w_at_max;
    logic              w_starve_inc;
    logic [ADDR_W:0]   w_dm_end;
    logic [ADDR_W:0]   w_if_end;
    logic              w_dm_oob;
    logic              w_if_oob;
    logic              w_f3_bad;
    logic              w_dm_block;
    logic              w_dm_err;
    logic              w_dm_load_ok;

    logic [31:0]       r_if_rdata;
    logic              r_if_valid;
    logic [31:0]       r_dm_rdata;
    logic              r_dm_valid;
    logic              r_dm_err;

    assign w_dm_req = i_dm_read | i_dm_write;

    // One extra bit so that address wrap-around shows up as out of range
    assign w_dm_end = {1'b0, i_dm_addr} + (ADDR_W + 1)'(f3_size(i_dm_funct3));
    assign w_if_end = {1'b0, i_if_addr} + (ADDR_W + 1)'(4);
    assign w_dm_oob = (w_dm_end > (ADDR_W + 1)'(MEM_BYTES));
    assign w_if_oob = (w_if_end > (ADDR_W + 1)'(MEM_BYTES));

    // Read+write together is handled as a store, so store encodings apply
    assign w_f3_bad = i_dm_write ? (i_dm_funct3 > F3_W)
                                 : (i_dm_funct3 inside {3'b011, 3'b110, 3'b111});

    // Block strobes on bad address or encoding; read+write still stores but flags an error
    assign w_dm_block = w_dm_oob | w_f3_bad;
    assign w_dm_err   = w_dm_block | (i_dm_read & i_dm_write);

    // Pick the winner: DM by default, fetch once it has starved for STARVE_MAX cycles
    always_comb begin
        w_gnt = GNT_NONE;
        if (w_dm_req && !(w_at_max && i_if_req)) begin
            w_gnt = GNT_DM;
        end else if (i_if_req) begin
            w_gnt = GNT_IF;
        end
    end

    assign o_if_gnt   = (w_gnt == GNT_IF);
    assign o_dm_gnt   = (w_gnt == GNT_DM);
    assign o_stall_if = i_if_req & ~o_if_gnt;
    assign o_stall_dm = w_dm_req & ~o_dm_gnt;

    assign w_dm_load_ok = o_dm_gnt & i_dm_read & ~i_dm_write & ~w_dm_err;
    assign w_starve_inc = o_stall_if;

    // Steer the memory port to the winning requester
    always_comb begin
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_funct3 = '0;
        case (w_gnt)
            GNT_IF: begin
                o_mem_read   = ~w_if_oob;
                o_mem_addr   = i_if_addr;
                o_mem_funct3 = F3_W;
            end
            GNT_DM: begin
                o_mem_read   = i_dm_read & ~i_dm_write & ~w_dm_block;
                o_mem_write  = i_dm_write & ~w_dm_block;
                o_mem_addr   = i_dm_addr;
                o_mem_wdata  = i_dm_wdata;
                o_mem_funct3 = i_dm_funct3;
            end
            default: ;
        endcase
    end

    mem_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_inc    (w_starve_inc),
        .i_clr    (~w_starve_inc),
        .o_at_max (w_at_max)
    );

    // Capture read data at the end of the granted cycle; valid/err pulse one cycle later
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_rdata <= '0;
            r_if_valid <= 1'b0;
            r_dm_rdata <= '0;
            r_dm_valid <= 1'b0;
            r_dm_err   <= 1'b0;
        end else begin
            r_if_valid <= o_if_gnt;
            r_dm_valid <= w_dm_load_ok;
            r_dm_err   <= o_dm_gnt & w_dm_err;
            if (o_if_gnt) begin
                r_if_rdata <= w_if_oob ? NOP_INSN : i_mem_rdata;
            end
            if (w_dm_load_ok) begin
                r_dm_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_if_rdata = r_if_rdata;
    assign o_if_valid = r_if_valid;
    assign o_dm_rdata = r_dm_rdata;
    assign o_dm_valid = r_dm_valid;
    assign o_dm_err   = r_dm_err;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if_stall;
    logic [31:0] r_perf_dm_gnt;

    // Free-running wrap-around event counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_if_stall <= '0;
            r_perf_dm_gnt   <= '0;
        end else begin
            if (o_stall_if) r_perf_if_stall <= r_perf_if_stall + 32'd1;
            if (o_dm_gnt)   r_perf_dm_gnt   <= r_perf_dm_gnt + 32'd1;
        end
    end

    assign o_perf_if_stall = r_perf_if_stall;
    assign o_perf_dm_gnt   = r_perf_dm_gnt;
`else
    assign o_perf_if_stall = '0;
    assign o_perf_dm_gnt   = '0;
`endif

endmodule
